// File: rtl/mem_arbiter_if.sv
// Shared signal bundle between the CPU/loader side and the memory arbiter.
// The master side drives CPU strobes and loader requests; the slave is the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        cpu_ctrl;
  logic [15:0]       cpu_bus;
  logic              cpu_boundary;
  logic              cpu_stall;
  logic              ld_mode;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [6:0]        ld_count;
  logic [7:0]        mem_ctrl;
  logic [15:0]       mem_bus;
  logic              owner;

  modport master (
    output cpu_ctrl, cpu_bus, cpu_boundary, ld_mode, ld_valid, ld_addr, ld_data,
    input  cpu_stall, ld_ready, ld_count, mem_ctrl, mem_bus, owner
  );

  modport slave (
    input  cpu_ctrl, cpu_bus, cpu_boundary, ld_mode, ld_valid, ld_addr, ld_data,
    output cpu_stall, ld_ready, ld_count, mem_ctrl, mem_bus, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the SAP-2 memory strobes/bus between the CPU and a byte-wide loader.
// The loader takes over at an instruction boundary and writes each byte as MAR -> MDR -> RAM.
module mem_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_CPU   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DATA  = 3'd4,
    ST_WRITE = 3'd5
  } state_t;

  localparam logic [7:0] CTRL_MAR = 8'h30;
  localparam logic [7:0] CTRL_MDR = 8'h08;
  localparam logic [7:0] CTRL_RAM = 8'h04;

  state_t            state_r;
  logic [6:0]        count_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        data_r;

  // Ownership/write-sequence FSM with loader byte latches and write counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_CPU;
      count_r <= 7'd0;
      addr_r  <= '0;
      data_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_CPU: begin
          if (bus.ld_mode) begin
            if (bus.cpu_boundary) begin
              state_r <= ST_IDLE;
              count_r <= 7'd0;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.ld_mode) begin
            state_r <= ST_CPU;
          end else if (bus.cpu_boundary) begin
            state_r <= ST_IDLE;
            count_r <= 7'd0;
          end
        end
        ST_IDLE: begin
          if (!bus.ld_mode) begin
            state_r <= ST_CPU;
          end else if (bus.ld_valid) begin
            addr_r  <= bus.ld_addr;
            data_r  <= bus.ld_data;
            state_r <= ST_ADDR;
          end
        end
        // Once a byte is accepted it always runs to completion.
        ST_ADDR: state_r <= ST_DATA;
        ST_DATA: state_r <= ST_WRITE;
        ST_WRITE: begin
          if (count_r != 7'd127) begin
            count_r <= count_r + 7'd1;
          end
          state_r <= bus.ld_mode ? ST_IDLE : ST_CPU;
        end
        default: state_r <= ST_CPU;
      endcase
    end
  end

  // Output decode: CPU passthrough or loader-generated strobes, from the registered state.
  always_comb begin
    bus.mem_ctrl  = bus.cpu_ctrl;
    bus.mem_bus   = bus.cpu_bus;
    bus.owner     = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.ld_ready  = 1'b0;
    case (state_r)
      ST_CPU, ST_WAIT: begin
        bus.mem_ctrl = bus.cpu_ctrl;
        bus.mem_bus  = bus.cpu_bus;
      end
      ST_IDLE: begin
        bus.owner     = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_ctrl  = 8'h00;
        bus.mem_bus   = 16'h0000;
        bus.ld_ready  = bus.ld_mode;
      end
      ST_ADDR: begin
        bus.owner     = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_ctrl  = CTRL_MAR;
        bus.mem_bus   = 16'(addr_r);
      end
      ST_DATA: begin
        bus.owner     = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_ctrl  = CTRL_MDR;
        bus.mem_bus   = {8'h00, data_r};
      end
      ST_WRITE: begin
        bus.owner     = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_ctrl  = CTRL_RAM;
        bus.mem_bus   = 16'h0000;
      end
      default: begin
        bus.owner     = 1'b1;
        bus.cpu_stall = 1'b1;
        bus.mem_ctrl  = 8'h00;
        bus.mem_bus   = 16'h0000;
      end
    endcase
  end

  assign bus.ld_count = count_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for handover/single write, then
// hand-written burst, late-release and reset-abort sequences against a small RAM model.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(6)) bus_if ();

  mem_arbiter #(.ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory-block model driven by the arbiter's strobes.
  logic [15:0] mar;
  logic [7:0]  mdr;
  logic [7:0]  ram [0:63];
  int          ram_writes = 0;

  always @(posedge clk) begin
    if (bus_if.mem_ctrl[5]) mar[15:8] <= bus_if.mem_bus[15:8];
    if (bus_if.mem_ctrl[4]) mar[7:0]  <= bus_if.mem_bus[7:0];
    if (bus_if.mem_ctrl[3]) mdr       <= bus_if.mem_bus[7:0];
    if (bus_if.mem_ctrl[2]) begin
      ram[mar[5:0]] <= mdr;
      ram_writes    <= ram_writes + 1;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] cctl, input logic [15:0] cbus,
                       input logic bnd, input logic mode, input logic valid,
                       input logic [5:0] addr, input logic [7:0] data);
    rst                 = r;
    bus_if.cpu_ctrl     = cctl;
    bus_if.cpu_bus      = cbus;
    bus_if.cpu_boundary = bnd;
    bus_if.ld_mode      = mode;
    bus_if.ld_valid     = valid;
    bus_if.ld_addr      = addr;
    bus_if.ld_data      = data;
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (b * 8'd37) ^ 8'h5A;
  endfunction

  typedef struct {
    logic        rst;
    logic [7:0]  cctl;
    logic [15:0] cbus;
    logic        bnd;
    logic        mode;
    logic        valid;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        chk;
    logic [7:0]  e_ctl;
    logic [15:0] e_bus;
    logic        e_own;
    logic        e_stall;
    logic        e_rdy;
    logic [6:0]  e_cnt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int k;
    int writes_before;
    logic [7:0] saved;

    //           rst   cctl   cbus      bnd   mode  valid addr   data  chk   e_ctl  e_bus     own   stall rdy   cnt
    vecs[0]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[1]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[2]  = '{1'b1, 8'h04, 16'h1234, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 8'h04, 16'h1234, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[3]  = '{1'b1, 8'hC1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'hC1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[4]  = '{1'b1, 8'h22, 16'h5555, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h22, 16'h5555, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[5]  = '{1'b1, 8'h03, 16'hA0A0, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h03, 16'hA0A0, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[6]  = '{1'b1, 8'h10, 16'h0F0F, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h10, 16'h0F0F, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[7]  = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 7'd0};
    vecs[8]  = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 6'h2A, 8'hC3, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 7'd0};
    vecs[9]  = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 6'h3F, 8'h55, 1'b1, 8'h30, 16'h002A, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[10] = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h08, 16'h00C3, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[11] = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h04, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd0};
    vecs[12] = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 7'd1};
    vecs[13] = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 6'h3F, 8'h55, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 7'd1};
    vecs[14] = '{1'b1, 8'h80, 16'h4321, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 8'h80, 16'h4321, 1'b0, 1'b0, 1'b0, 7'd1};

    drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);

    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive(vecs[i].rst, vecs[i].cctl, vecs[i].cbus, vecs[i].bnd, vecs[i].mode,
            vecs[i].valid, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d_mem_ctrl", i), 32'(bus_if.mem_ctrl), 32'(vecs[i].e_ctl));
        check($sformatf("v%0d_mem_bus", i), 32'(bus_if.mem_bus), 32'(vecs[i].e_bus));
        check($sformatf("v%0d_owner", i), 32'(bus_if.owner), 32'(vecs[i].e_own));
        check($sformatf("v%0d_cpu_stall", i), 32'(bus_if.cpu_stall), 32'(vecs[i].e_stall));
        check($sformatf("v%0d_ld_ready", i), 32'(bus_if.ld_ready), 32'(vecs[i].e_rdy));
        check($sformatf("v%0d_ld_count", i), 32'(bus_if.ld_count), 32'(vecs[i].e_cnt));
      end
    end
    check("single_ram_2a", 32'(ram[6'h2A]), 32'h000000C3);

    // Burst of 64 bytes with ld_valid held high.
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 6'h00, pat(0));
    idx = 0;
    k = 0;
    while (k < 300 && idx < 64) begin
      next_cycle();
      drive(1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 6'(idx), pat(idx));
      @(negedge clk);
      if (k == 0) check("burst_count_cleared", 32'(bus_if.ld_count), 32'd0);
      check($sformatf("burst_ready_k%0d", k), 32'(bus_if.ld_ready), 32'((k % 4) == 0));
      if (bus_if.ld_ready) idx++;
      k++;
    end
    check("burst_accepts", 32'(idx), 32'd64);
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      drive(1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
    end
    next_cycle();
    @(negedge clk);
    check("burst_final_ready", 32'(bus_if.ld_ready), 32'd1);
    check("burst_count_64", 32'(bus_if.ld_count), 32'd64);
    next_cycle();
    drive(1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("release_owner_hold", 32'(bus_if.owner), 32'd1);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("release_owner", 32'(bus_if.owner), 32'd0);
    check("release_stall", 32'(bus_if.cpu_stall), 32'd0);
    for (int a = 0; a < 64; a++) begin
      check($sformatf("burst_ram_%0d", a), 32'(ram[a]), 32'(pat(a)));
    end

    // ld_mode dropped in L_DATA: byte still completes, then CPU regains the bus.
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 6'h05, 8'h77);
    @(negedge clk);
    check("drop_accept_ready", 32'(bus_if.ld_ready), 32'd1);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("drop_addr_ctrl", 32'(bus_if.mem_ctrl), 32'h30);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("drop_data_ctrl", 32'(bus_if.mem_ctrl), 32'h08);
    check("drop_data_owner", 32'(bus_if.owner), 32'd1);
    next_cycle();
    @(negedge clk);
    check("drop_write_ctrl", 32'(bus_if.mem_ctrl), 32'h04);
    check("drop_write_owner", 32'(bus_if.owner), 32'd1);
    next_cycle();
    drive(1'b1, 8'h0C, 16'h1111, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("drop_pass_ctrl", 32'(bus_if.mem_ctrl), 32'h0C);
    check("drop_pass_bus", 32'(bus_if.mem_bus), 32'h1111);
    check("drop_pass_owner", 32'(bus_if.owner), 32'd0);
    check("drop_count", 32'(bus_if.ld_count), 32'd1);
    check("drop_ram_05", 32'(ram[6'h05]), 32'h77);

    // Reset during L_DATA abandons the byte.
    saved = ram[6'h11];
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 6'h00, 8'h00);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 6'h11, 8'hEE);
    @(negedge clk);
    writes_before = ram_writes;
    check("rst_accept_ready", 32'(bus_if.ld_ready), 32'd1);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("rst_addr_bus", 32'(bus_if.mem_bus), 32'h0011);
    next_cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("rst_data_ctrl", 32'(bus_if.mem_ctrl), 32'h08);
    next_cycle();
    drive(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    check("rst_after_ctrl", 32'(bus_if.mem_ctrl), 32'h00);
    check("rst_after_owner", 32'(bus_if.owner), 32'd0);
    check("rst_after_stall", 32'(bus_if.cpu_stall), 32'd0);
    check("rst_after_count", 32'(bus_if.ld_count), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rst_no_ram_load", 32'(ram_writes), 32'(writes_before));
    check("rst_ram_11_kept", 32'(ram[6'h11]), 32'(saved));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter in front of the SAP-2 memory block: it shares the memory's control strobes and 16-bit bus between the CPU control unit and a byte-wide program-loader port. In load mode it takes ownership at an instruction boundary, stalls the CPU, and writes each loader byte through a MAR → MDR → RAM-write sequence. Otherwise CPU strobes and bus pass straight through.

## Interface
- ADDR_W, 6, loader address width (64-byte RAM)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_ctrl  in  8  CPU memory strobes {call, ret, mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl} (bit 7..0)
- cpu_bus  in  16  CPU bus value
- cpu_boundary  in  1  high in the cycle the CPU completes an instruction (safe handover point)
- cpu_stall  out  1  CPU must hold its state
- ld_mode  in  1  loader requests memory ownership
- ld_valid  in  1  loader byte available
- ld_addr  in  ADDR_W  target RAM address
- ld_data  in  8  byte to write
- ld_ready  out  1  arbiter accepts a byte this cycle
- ld_count  out  7  bytes written since ownership was last granted (saturates at 127)
- mem_ctrl  out  8  strobes to memory, same bit order as cpu_ctrl
- mem_bus  out  16  bus value to memory
- owner  out  1  0 = CPU, 1 = loader

## Operation
- States: CPU, WAIT, L_IDLE, L_ADDR, L_DATA, L_WRITE (registered state; outputs decoded from state).
- CPU: mem_ctrl = cpu_ctrl, mem_bus = cpu_bus, owner 0, cpu_stall 0, ld_ready 0. ld_mode && cpu_boundary → L_IDLE. ld_mode && !cpu_boundary → WAIT.
- WAIT: same outputs as CPU (the CPU finishes its instruction). cpu_boundary → L_IDLE. ld_mode low → CPU.
- Entry to L_IDLE from CPU/WAIT clears ld_count to 0.
- L_* states: owner 1, cpu_stall 1, cpu_ctrl fully masked.
- L_IDLE: mem_ctrl 0, mem_bus 0, ld_ready = ld_mode. ld_valid && ld_ready → latch ld_addr/ld_data, go to L_ADDR. ld_mode low → CPU.
- L_ADDR: mem_ctrl = mar_loadh|mar_loadl, mem_bus = {8'h00, zero-extended latched addr}.
- L_DATA: mem_ctrl = mdr_load, mem_bus = {8'h00, latched data}.
- L_WRITE: mem_ctrl = ram_load, mem_bus = 0. ld_count += 1 (saturating at 127). Next state is L_IDLE if ld_mode is high, else CPU.
- Dropping ld_mode in L_ADDR/L_DATA does not abort: the byte completes, then control returns to CPU after L_WRITE.
- call/ret are never generated by the loader path.

## Timing
- Reset (rst low at clock edge, any state): state CPU, ld_count 0, latches 0. Outputs in the following cycle: owner 0, cpu_stall 0, ld_ready 0, mem_ctrl = cpu_ctrl (passthrough).
- Handover latency: ld_mode && cpu_boundary at edge N gives owner 1 and cpu_stall 1 from cycle N+1.
- Byte write takes 4 cycles: accept (L_IDLE) → L_ADDR → L_DATA → L_WRITE. Throughput is 1 byte per 4 cycles. ld_ready is low for the 3 cycles after acceptance.
- Data is in RAM after the edge ending L_WRITE.
- Release latency: ld_mode low in L_IDLE gives owner 0 in the next cycle. ld_mode low during L_ADDR, L_DATA or L_WRITE gives owner 0 in the cycle after L_WRITE.
- Simultaneous ld_valid and falling ld_mode in L_IDLE: ld_ready is already 0, so no byte is accepted.
- Reset during L_ADDR/L_DATA: the byte is abandoned and no ram_load is issued.

## Test plan
- Reset passthrough: hold rst=0 for 2 cycles, release, drive cpu_ctrl=8'h04, cpu_bus=16'h1234 → next cycle mem_ctrl=8'h04, mem_bus=16'h1234, owner 0, cpu_stall 0.
- Deferred handover: ld_mode=1 with cpu_boundary=0 for 3 cycles, then 1 → CPU strobes pass for those 3 cycles; owner=1 and cpu_stall=1 starting the cycle after the boundary.
- Single write: in L_IDLE send addr 6'h2A, data 8'hC3 → mem_ctrl 8'h30 with bus 16'h002A, then 8'h08 with bus 16'h00C3, then 8'h04. RAM[0x2A]=C3 after that edge; ld_count=1.
- Burst: send 64 bytes back-to-back with ld_valid held high → ld_ready asserts every 4th cycle; ld_count=64; all 64 locations read back correctly after release.
- ld_mode dropped in L_DATA → ram_load is still issued; owner 0 in the cycle after L_WRITE; cpu_ctrl passes through again.
- Reset in L_DATA → no ram_load issued; state CPU; ld_count 0; target RAM byte unchanged.
